vector_pe_sequencer: RTL and testbench

//  Upstream issue stage for vector_processing_element. Accepts one vector op per command handshake.

---
 rtl/vpe_pkg.sv | 43 ++++
 rtl/vpe_len_calc.sv | 57 +++++
 rtl/vector_pe_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_vector_pe_sequencer.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vpe_pkg
// Brief   : Shared opcodes, SEW constants, FSM states and helpers for the
//           vector PE sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package vpe_pkg;

    localparam logic [7:0] c_op_vadd      = 8'h00;
    localparam logic [7:0] c_op_vmul      = 8'h01;
    localparam logic [7:0] c_op_vdot      = 8'h02;
    localparam logic [7:0] c_op_vadd_varp = 8'h03;
    localparam logic [7:0] c_op_vmul_varp = 8'h04;
    localparam logic [7:0] c_op_vdot_varp = 8'h05;
    localparam logic [7:0] c_op_vmac      = 8'h06;
    localparam logic [7:0] c_op_vmac_varp = 8'h07;
    localparam logic [7:0] c_op_max       = 8'h07;

    localparam logic [9:0] c_sew_8  = 10'd8;
    localparam logic [9:0] c_sew_16 = 10'd16;
    localparam logic [9:0] c_sew_32 = 10'd32;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_EXEC = 3'd2,
        S_WAIT = 3'd3,
        S_WB   = 3'd4,
        S_DONE = 3'd5
    } vpe_state_t;

    function automatic logic is_varp(input logic [7:0] op);
        return op inside {c_op_vadd_varp, c_op_vmul_varp, c_op_vdot_varp, c_op_vmac_varp};
    endfunction

    function automatic logic is_mul(input logic [7:0] op);
        return op inside {c_op_vmul, c_op_vdot, c_op_vmul_varp, c_op_vdot_varp,
                          c_op_vmac, c_op_vmac_varp};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vpe_len_calc.sv
`default_nettype none
// ============================================================================
// Module  : vpe_len_calc
// Brief   : Word count, tail byte strobe and command legality for one op.
// Revision: 1.0 - initial release
// ============================================================================
module vpe_len_calc #(
    parameter int WORDS_PER_VREG = 8,
    parameter int VL_W           = 8,
    parameter int CNT_W          = $clog2(WORDS_PER_VREG + 1)
) (
    input  logic [VL_W-1:0]  i_vl,
    input  logic [9:0]       i_sew,
    input  logic [3:0]       i_vap,
    input  logic [7:0]       i_instr,
    output logic [CNT_W-1:0] o_nw,
    output logic [3:0]       o_tail_strb,
    output logic             o_err,
    output logic             o_vl_zero
);
    import vpe_pkg::*;

    localparam int c_prod_w = VL_W + 11;

    logic [9:0]          w_ew;
    logic [c_prod_w-1:0] w_bits;
    logic [c_prod_w-1:0] w_nw_full;
    logic                w_sew_bad;
    logic                w_vap_bad;
    logic                w_op_bad;
    logic                w_len_bad;

    always_comb begin
        w_ew      = is_varp(i_instr) ? c_sew_8 : i_sew;
        w_bits    = c_prod_w'(i_vl) * c_prod_w'(w_ew);
        w_nw_full = (w_bits + c_prod_w'(31)) >> 5;

        w_sew_bad = !(i_sew inside {c_sew_8, c_sew_16, c_sew_32});
        w_vap_bad = is_varp(i_instr) && !(i_vap inside {4'd1, 4'd2, 4'd4, 4'd8});
        w_op_bad  = i_instr > c_op_max;
        w_len_bad = w_nw_full > c_prod_w'(WORDS_PER_VREG);

        o_err     = w_sew_bad || w_vap_bad || w_op_bad || w_len_bad;
        o_vl_zero = (i_vl == '0);
        o_nw      = w_nw_full[CNT_W-1:0];

        // Bytes in the final word: total bytes modulo 4, zero meaning a full word
        case (w_bits[4:3])
            2'd1:    o_tail_strb = 4'h1;
            2'd2:    o_tail_strb = 4'h3;
            2'd3:    o_tail_strb = 4'h7;
            default: o_tail_strb = 4'hF;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/vector_pe_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : vector_pe_sequencer
// Brief   : Issues one vector op word-by-word: VRF read, PE start/done, VRF write.
// Revision: 1.0 - initial release
// ============================================================================
module vector_pe_sequencer #(
    parameter int WORDS_PER_VREG = 8,
    parameter int VL_W           = 8,
    parameter int PE_TIMEOUT     = 64
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic [7:0]                          cmd_instr,
    input  logic [4:0]                          cmd_vs1,
    input  logic [4:0]                          cmd_vs2,
    input  logic [4:0]                          cmd_vd,
    input  logic [VL_W-1:0]                     cmd_vl,
    input  logic [9:0]                          cmd_sew,
    input  logic [3:0]                          cmd_vap,
    output logic [5+$clog2(WORDS_PER_VREG)-1:0] rf_raddr_a,
    output logic [5+$clog2(WORDS_PER_VREG)-1:0] rf_raddr_b,
    output logic [5+$clog2(WORDS_PER_VREG)-1:0] rf_raddr_c,
    input  logic [31:0]                         rf_rdata_a,
    input  logic [31:0]                         rf_rdata_b,
    input  logic [31:0]                         rf_rdata_c,
    output logic                                rf_we,
    output logic [3:0]                          rf_wstrb,
    output logic [5+$clog2(WORDS_PER_VREG)-1:0] rf_waddr,
    output logic [31:0]                         rf_wdata,
    output logic [7:0]                          pe_instruction,
    output logic                                pe_start,
    output logic [9:0]                          pe_sew,
    output logic [3:0]                          pe_vap,
    output logic [31:0]                         pe_opA,
    output logic [31:0]                         pe_opB,
    output logic [31:0]                         pe_opC,
    input  logic                                pe_done,
    input  logic [31:0]                         pe_out,
    output logic                                cmd_done,
    output logic                                cmd_err
);
    import vpe_pkg::*;

    localparam int c_word_w = $clog2(WORDS_PER_VREG);
    localparam int c_cnt_w  = $clog2(WORDS_PER_VREG + 1);
    localparam int c_tmo_w  = $clog2(PE_TIMEOUT + 1);

    vpe_state_t          r_state;
    logic [7:0]          r_instr;
    logic [4:0]          r_vs1;
    logic [4:0]          r_vs2;
    logic [4:0]          r_vd;
    logic [9:0]          r_sew;
    logic [3:0]          r_vap;
    logic [c_cnt_w-1:0]  r_nw;
    logic [3:0]          r_tail_strb;
    logic [c_word_w-1:0] r_idx;
    logic [c_tmo_w-1:0]  r_tmo;

    logic [c_cnt_w-1:0]  w_nw;
    logic [3:0]          w_tail_strb;
    logic                w_err;
    logic                w_vl_zero;
    logic                w_last;
    logic [c_word_w-1:0] w_idx_next;

    vpe_len_calc #(
        .WORDS_PER_VREG (WORDS_PER_VREG),
        .VL_W           (VL_W),
        .CNT_W          (c_cnt_w)
    ) u_len_calc (
        .i_vl        (cmd_vl),
        .i_sew       (cmd_sew),
        .i_vap       (cmd_vap),
        .i_instr     (cmd_instr),
        .o_nw        (w_nw),
        .o_tail_strb (w_tail_strb),
        .o_err       (w_err),
        .o_vl_zero   (w_vl_zero)
    );

    assign w_last     = (c_cnt_w'(r_idx) + c_cnt_w'(1)) == r_nw;
    assign w_idx_next = r_idx + c_word_w'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_instr        <= '0;
            r_vs1          <= '0;
            r_vs2          <= '0;
            r_vd           <= '0;
            r_sew          <= '0;
            r_vap          <= '0;
            r_nw           <= '0;
            r_tail_strb    <= '0;
            r_idx          <= '0;
            r_tmo          <= '0;
            cmd_ready      <= 1'b1;
            rf_raddr_a     <= '0;
            rf_raddr_b     <= '0;
            rf_raddr_c     <= '0;
            rf_we          <= 1'b0;
            rf_wstrb       <= '0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            pe_instruction <= '0;
            pe_start       <= 1'b0;
            pe_sew         <= '0;
            pe_vap         <= '0;
            pe_opA         <= '0;
            pe_opB         <= '0;
            pe_opC         <= '0;
            cmd_done       <= 1'b0;
            cmd_err        <= 1'b0;
        end else begin
            cmd_done <= 1'b0;
            cmd_err  <= 1'b0;
            rf_we    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_instr     <= cmd_instr;
                        r_vs1       <= cmd_vs1;
                        r_vs2       <= cmd_vs2;
                        r_vd        <= cmd_vd;
                        r_sew       <= cmd_sew;
                        r_vap       <= cmd_vap;
                        r_nw        <= w_nw;
                        r_tail_strb <= w_tail_strb;
                        r_idx       <= '0;
                        cmd_ready   <= 1'b0;
                        if (w_err || w_vl_zero) begin
                            cmd_done <= 1'b1;
                            cmd_err  <= w_err;
                            r_state  <= S_DONE;
                        end else begin
                            rf_raddr_a <= {cmd_vs1, {c_word_w{1'b0}}};
                            rf_raddr_b <= {cmd_vs2, {c_word_w{1'b0}}};
                            rf_raddr_c <= {cmd_vd,  {c_word_w{1'b0}}};
                            r_state    <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    pe_opA         <= rf_rdata_a;
                    pe_opB         <= rf_rdata_b;
                    pe_opC         <= rf_rdata_c;
                    pe_instruction <= r_instr;
                    pe_sew         <= r_sew;
                    pe_vap         <= r_vap;
                    pe_start       <= 1'b1;
                    r_tmo          <= '0;
                    r_state        <= S_WAIT;
                end
                S_WAIT: begin
                    if (pe_done) begin
                        pe_start <= 1'b0;
                        rf_we    <= 1'b1;
                        rf_waddr <= {r_vd, r_idx};
                        rf_wdata <= pe_out;
                        rf_wstrb <= w_last ? r_tail_strb : 4'hF;
                        r_state  <= S_WB;
                    end else if (r_tmo == c_tmo_w'(PE_TIMEOUT - 1)) begin
                        pe_start <= 1'b0;
                        cmd_done <= 1'b1;
                        cmd_err  <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + c_tmo_w'(1);
                    end
                end
                S_WB: begin
                    // Next read is issued only after this write, so vs1/vs2 == vd is safe
                    if (w_last) begin
                        cmd_done <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_idx      <= w_idx_next;
                        rf_raddr_a <= {r_vs1, w_idx_next};
                        rf_raddr_b <= {r_vs2, w_idx_next};
                        rf_raddr_c <= {r_vd,  w_idx_next};
                        r_state    <= S_RD;
                    end
                end
                S_DONE: begin
                    cmd_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    pe_start  <= 1'b0;
                    cmd_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vector_pe_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_vector_pe_sequencer
// Brief   : Directed bench with VRF/PE models and an op-level expectation model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vector_pe_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_instr;
    logic [4:0]  cmd_vs1, cmd_vs2, cmd_vd;
    logic [7:0]  cmd_vl;
    logic [9:0]  cmd_sew;
    logic [3:0]  cmd_vap;
    logic [7:0]  rf_raddr_a, rf_raddr_b, rf_raddr_c, rf_waddr;
    logic [31:0] rf_rdata_a, rf_rdata_b, rf_rdata_c, rf_wdata;
    logic        rf_we;
    logic [3:0]  rf_wstrb;
    logic [7:0]  pe_instruction;
    logic        pe_start;
    logic [9:0]  pe_sew;
    logic [3:0]  pe_vap;
    logic [31:0] pe_opA, pe_opB, pe_opC;
    logic        pe_done;
    logic [31:0] pe_out;
    logic        cmd_done, cmd_err;

    vector_pe_sequencer #(
        .WORDS_PER_VREG (8),
        .VL_W           (8),
        .PE_TIMEOUT     (64)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_instr      (cmd_instr),
        .cmd_vs1        (cmd_vs1),
        .cmd_vs2        (cmd_vs2),
        .cmd_vd         (cmd_vd),
        .cmd_vl         (cmd_vl),
        .cmd_sew        (cmd_sew),
        .cmd_vap        (cmd_vap),
        .rf_raddr_a     (rf_raddr_a),
        .rf_raddr_b     (rf_raddr_b),
        .rf_raddr_c     (rf_raddr_c),
        .rf_rdata_a     (rf_rdata_a),
        .rf_rdata_b     (rf_rdata_b),
        .rf_rdata_c     (rf_rdata_c),
        .rf_we          (rf_we),
        .rf_wstrb       (rf_wstrb),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .pe_instruction (pe_instruction),
        .pe_start       (pe_start),
        .pe_sew         (pe_sew),
        .pe_vap         (pe_vap),
        .pe_opA         (pe_opA),
        .pe_opB         (pe_opB),
        .pe_opC         (pe_opC),
        .pe_done        (pe_done),
        .pe_out         (pe_out),
        .cmd_done       (cmd_done),
        .cmd_err        (cmd_err)
    );

    always #5 clk = ~clk;

    // PE semantics: lane-wise add / mul / mac, or dot product accumulated onto C
    function automatic logic [31:0] pe_calc(input logic [7:0] op, input logic [9:0] sew,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c);
        int          ew;
        int          kind;
        logic [31:0] mask, la, lb, lc, res, r, acc;
        ew   = (op == 8'd3 || op == 8'd4 || op == 8'd5 || op == 8'd7) ? 8 : int'(sew);
        if (ew != 8 && ew != 16 && ew != 32) ew = 32;
        kind = (op == 8'd3) ? 0 : (op == 8'd4) ? 1 : (op == 8'd5) ? 2 : (op == 8'd7) ? 6 : int'(op);
        mask = (ew == 32) ? 32'hFFFF_FFFF : ((32'd1 << ew) - 32'd1);
        r    = 32'd0;
        acc  = c;
        for (int l = 0; l < 32 / ew; l++) begin
            la = (a >> (l * ew)) & mask;
            lb = (b >> (l * ew)) & mask;
            lc = (c >> (l * ew)) & mask;
            case (kind)
                0:       res = la + lb;
                1:       res = la * lb;
                6:       res = la * lb + lc;
                default: res = 32'd0;
            endcase
            if (kind == 2) acc = acc + la * lb;
            r = r | ((res & mask) << (l * ew));
        end
        return (kind == 2) ? acc : r;
    endfunction

    // Vector register file: 1-cycle read latency, byte-strobed writes
    logic [31:0] rf_mem [0:255];
    always @(posedge clk) begin
        rf_rdata_a <= rf_mem[rf_raddr_a];
        rf_rdata_b <= rf_mem[rf_raddr_b];
        rf_rdata_c <= rf_mem[rf_raddr_c];
        if (rf_we)
            for (int b = 0; b < 4; b++)
                if (rf_wstrb[b]) rf_mem[rf_waddr][8*b +: 8] <= rf_wdata[8*b +: 8];
    end

    int pe_lat;
    bit pe_hang;
    int pe_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset || !pe_start) pe_cnt <= 0;
        else                    pe_cnt <= pe_cnt + 1;
    end
    assign pe_done = pe_start && !pe_hang && (pe_cnt >= pe_lat);
    assign pe_out  = pe_calc(pe_instruction, pe_sew, pe_opA, pe_opB, pe_opC);

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic [31:0] exp_rf [0:255];
    wr_t         exp_wq[$];
    bit          exp_done_q[$];
    int          checks = 0;
    int          errors = 0;
    int          wr_count = 0;
    int          start_cycles = 0;

    function automatic logic [7:0] vaddr(input int vreg, input int w);
        return 8'(vreg * 8 + w);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic preload(input int vreg, input int w, input logic [31:0] val);
        rf_mem[vaddr(vreg, w)] = val;
        exp_rf[vaddr(vreg, w)] = val;
    endtask

    // Op-level expectation: legality, word count, tail strobe, per-word results
    task automatic model_cmd(input int op, input int vs1, input int vs2, input int vd,
                             input int vl, input int sew, input int vap);
        int  ew, nw, rem;
        bit  varp, bad;
        wr_t e;
        varp = (op == 3 || op == 4 || op == 5 || op == 7);
        ew   = varp ? 8 : sew;
        bad  = !(sew == 8 || sew == 16 || sew == 32) ||
               (varp && !(vap == 1 || vap == 2 || vap == 4 || vap == 8)) || (op > 7);
        nw   = (vl * ew + 31) / 32;
        if (nw > 8) bad = 1;
        if (bad) begin
            exp_done_q.push_back(1'b1);
        end else begin
            rem = (vl * ew / 8) % 4;
            for (int w = 0; w < nw; w++) begin
                e.addr = vaddr(vd, w);
                e.strb = (w == nw - 1 && rem != 0) ? 4'((1 << rem) - 1) : 4'hF;
                e.data = pe_calc(8'(op), 10'(sew), exp_rf[vaddr(vs1, w)],
                                 exp_rf[vaddr(vs2, w)], exp_rf[vaddr(vd, w)]);
                exp_wq.push_back(e);
            end
            exp_done_q.push_back(1'b0);
        end
    endtask

    task automatic drive_fields(input int op, input int vs1, input int vs2, input int vd,
                                input int vl, input int sew, input int vap);
        cmd_instr = 8'(op);
        cmd_vs1   = 5'(vs1);
        cmd_vs2   = 5'(vs2);
        cmd_vd    = 5'(vd);
        cmd_vl    = 8'(vl);
        cmd_sew   = 10'(sew);
        cmd_vap   = 4'(vap);
    endtask

    task automatic launch(input int op, input int vs1, input int vs2, input int vd,
                          input int vl, input int sew, input int vap);
        int k = 0;
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("launch_ready", {63'd0, cmd_ready}, 64'd1);
        drive_fields(op, vs1, vs2, vd, vl, sew, vap);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit err);
        int k = 0;
        while (!cmd_done && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_done) begin
            errors++;
            checks++;
            $display("FAIL done_timeout actual=none required=cmd_done");
        end
        lat = k;
        err = cmd_err;
    endtask

    task automatic do_cmd(input int op, input int vs1, input int vs2, input int vd,
                          input int vl, input int sew, input int vap,
                          output int lat, output bit err);
        model_cmd(op, vs1, vs2, vd, vl, sew, vap);
        launch(op, vs1, vs2, vd, vl, sew, vap);
        wait_done(lat, err);
    endtask

    task automatic err_case(input string name, input int op, input int vl, input int sew,
                            input int vap, input bit req_err);
        int lat, w0, s0;
        bit err;
        w0 = wr_count;
        s0 = start_cycles;
        do_cmd(op, 1, 2, 30, vl, sew, vap, lat, err);
        check({name, "_lat"}, 64'(lat), 64'd0);
        check({name, "_err"}, {63'd0, err}, {63'd0, req_err});
        check({name, "_noact"}, 64'((wr_count - w0) + (start_cycles - s0)), 64'd0);
    endtask

    // Per-cycle compare against the expectation queues
    initial begin
        logic         prev_start;
        logic [117:0] prev_ctl;
        wr_t          e;
        prev_start = 1'b0;
        prev_ctl   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_start = 1'b0;
            end else begin
                if (pe_start) start_cycles++;
                if (rf_we) begin
                    checks++;
                    wr_count++;
                    if (exp_wq.size() == 0) begin
                        errors++;
                        $display("FAIL wr_unexpected actual=%h:%h:%h required=none",
                                 rf_waddr, rf_wdata, rf_wstrb);
                    end else begin
                        e = exp_wq.pop_front();
                        if ({rf_waddr, rf_wdata, rf_wstrb} !== {e.addr, e.data, e.strb}) begin
                            errors++;
                            $display("FAIL wr_data actual=%h:%h:%h required=%h:%h:%h",
                                     rf_waddr, rf_wdata, rf_wstrb, e.addr, e.data, e.strb);
                        end
                        for (int b = 0; b < 4; b++)
                            if (e.strb[b]) exp_rf[e.addr][8*b +: 8] = e.data[8*b +: 8];
                    end
                end
                if (cmd_done) begin
                    checks++;
                    if (exp_done_q.size() == 0) begin
                        errors++;
                        $display("FAIL done_unexpected actual=err%0b required=none", cmd_err);
                    end else if (cmd_err !== exp_done_q.pop_front()) begin
                        errors++;
                        $display("FAIL done_err actual=%0b required=%0b", cmd_err, !cmd_err);
                    end
                end
                if (pe_start && prev_start) begin
                    checks++;
                    if ({pe_opA, pe_opB, pe_opC, pe_instruction, pe_sew, pe_vap} !== prev_ctl) begin
                        errors++;
                        $display("FAIL pe_stable actual=%h required=%h",
                                 {pe_opA, pe_opB, pe_opC, pe_instruction, pe_sew, pe_vap}, prev_ctl);
                    end
                end
                if (pe_start || rf_we) begin
                    checks++;
                    if (cmd_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL busy_ready actual=%0b required=0", cmd_ready);
                    end
                end
                prev_start = pe_start;
                prev_ctl   = {pe_opA, pe_opB, pe_opC, pe_instruction, pe_sew, pe_vap};
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, w0, s0, k;
        bit err;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        drive_fields(0, 0, 0, 0, 0, 0, 0);
        pe_lat    = 2;
        pe_hang   = 1'b0;
        for (int i = 0; i < 256; i++) begin
            rf_mem[i] = 32'd0;
            exp_rf[i] = 32'd0;
        end
        repeat (2) @(negedge clk);
        check("rst_ready", {63'd0, cmd_ready}, 64'd1);
        check("rst_outs", {rf_we, pe_start, cmd_done, cmd_err, rf_wstrb, rf_waddr, rf_raddr_a},
              64'd0);
        check("rst_pe", {pe_instruction, pe_sew, pe_vap, pe_opA[7:0]}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // vadd SEW32 vl=3
        for (int w = 0; w < 3; w++) begin
            preload(1, w, 32'(w + 1));
            preload(2, w, 32'(10 * (w + 1)));
            preload(3, w, 32'hDEAD_0000);
        end
        w0 = wr_count;
        do_cmd(0, 1, 2, 3, 3, 32, 1, lat, err);
        check("vadd_w0", rf_mem[vaddr(3, 0)], 64'd11);
        check("vadd_w1", rf_mem[vaddr(3, 1)], 64'd22);
        check("vadd_w2", rf_mem[vaddr(3, 2)], 64'd33);
        check("vadd_writes", 64'(wr_count - w0), 64'd3);
        check("vadd_lat", 64'(lat), 64'd18);

        // Back-to-back: valid raised during DONE waits for IDLE
        check("done_ready", {63'd0, cmd_ready}, 64'd0);
        model_cmd(0, 1, 2, 13, 1, 32, 1);
        drive_fields(0, 1, 2, 13, 1, 32, 1);
        cmd_valid = 1'b1;
        @(negedge clk);
        check("b2b_idle_ready", {63'd0, cmd_ready}, 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_accepted", {63'd0, cmd_ready}, 64'd0);
        wait_done(lat, err);
        check("b2b_result", rf_mem[vaddr(13, 0)], 64'd11);

        // vmul SEW8 vl=6: partial second word
        for (int w = 0; w < 2; w++) begin
            preload(4, w, 32'h0303_0303);
            preload(5, w, 32'hFEFE_FEFE);
        end
        preload(6, 0, 32'h1111_1111);
        preload(6, 1, 32'h2222_2222);
        do_cmd(1, 4, 5, 6, 6, 8, 1, lat, err);
        check("vmul_w0", rf_mem[vaddr(6, 0)], 64'hFAFA_FAFA);
        check("vmul_w1", rf_mem[vaddr(6, 1)], 64'h2222_FAFA);

        // vdot SEW16 vl=2
        preload(7, 0, 32'd5);
        preload(8, 0, 32'd7);
        preload(9, 0, 32'd100);
        do_cmd(2, 7, 8, 9, 2, 16, 1, lat, err);
        check("vdot_w0", rf_mem[vaddr(9, 0)], 64'h87);

        // varp add forces EW=8 regardless of SEW: vl=5 -> 1-byte tail
        for (int w = 0; w < 2; w++) begin
            preload(14, w, 32'h0403_0201);
            preload(15, w, 32'h1010_1010);
            preload(16, w, 32'h5555_5555);
        end
        do_cmd(3, 14, 15, 16, 5, 32, 1, lat, err);
        check("varp_w0", rf_mem[vaddr(16, 0)], 64'h1413_1211);
        check("varp_w1", rf_mem[vaddr(16, 1)], 64'h5555_5511);

        // Full register: NW == WORDS_PER_VREG, vs1 aliases vd
        for (int w = 0; w < 8; w++) begin
            preload(20, w, $urandom);
            preload(21, w, $urandom);
        end
        do_cmd(6, 20, 21, 20, 8, 32, 1, lat, err);
        check("full_err", {63'd0, err}, 64'd0);

        // Rejected / empty commands
        err_case("sew12",   0, 4,  12, 1, 1'b1);
        err_case("vap3",    3, 4,  8,  3, 1'b1);
        err_case("op8",     8, 4,  8,  1, 1'b1);
        err_case("nw9",     0, 9,  32, 1, 1'b1);
        err_case("vl0",     0, 0,  16, 1, 1'b0);

        // PE never answers: timeout after 64 WAIT cycles
        pe_hang = 1'b1;
        preload(17, 0, 32'h1234_5678);
        exp_done_q.push_back(1'b1);
        w0 = wr_count;
        s0 = start_cycles;
        launch(0, 1, 2, 17, 1, 32, 1);
        wait_done(lat, err);
        check("tmo_lat", 64'(lat), 64'd66);
        check("tmo_err", {63'd0, err}, 64'd1);
        check("tmo_start_low", {63'd0, pe_start}, 64'd0);
        check("tmo_start_cycles", 64'(start_cycles - s0), 64'd64);
        check("tmo_nowrite", 64'(wr_count - w0), 64'd0);
        check("tmo_vd", rf_mem[vaddr(17, 0)], 64'h1234_5678);
        pe_hang = 1'b0;

        // Reset during WAIT of word 1
        pe_lat = 10;
        for (int w = 0; w < 3; w++) begin
            preload(10, w, 32'(100 * (w + 1)));
            preload(11, w, 32'(w + 1));
            preload(12, w, 32'hAAAA_0000 + 32'(w));
        end
        model_cmd(0, 10, 11, 12, 3, 32, 1);
        launch(0, 10, 11, 12, 3, 32, 1);
        w0 = wr_count;
        k  = 0;
        while (wr_count == w0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        while (!pe_start && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("rst_reach_wait1", {63'd0, pe_start}, 64'd1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_start", {63'd0, pe_start}, 64'd0);
        check("rst_mid_ready", {63'd0, cmd_ready}, 64'd1);
        check("rst_mid_we_done", {62'd0, rf_we, cmd_done}, 64'd0);
        exp_wq.delete();
        exp_done_q.delete();
        @(negedge clk);
        reset = 1'b0;
        check("rst_vd_w0", rf_mem[vaddr(12, 0)], 64'd101);
        check("rst_vd_w1", rf_mem[vaddr(12, 1)], 64'hAAAA_0001);
        pe_lat = 2;
        @(negedge clk);
        do_cmd(0, 10, 11, 12, 3, 32, 1, lat, err);
        check("post_rst_w1", rf_mem[vaddr(12, 1)], 64'd202);
        check("post_rst_w2", rf_mem[vaddr(12, 2)], 64'd303);

        repeat (3) @(negedge clk);
        check("q_empty", 64'(exp_wq.size() + exp_done_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
